var_name_table: RTL and testbench

//  Variable memory stage: consumes the null-terminated name byte stream that the instruction controller

---
 rtl/var_name_table.sv | 171 +++++++++++++++++
 tb/tb_var_name_table.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/var_name_table.sv
// Variable name table: collects a null-terminated name byte stream, then looks up or defines a named value.
// Latency: terminator in cycle T -> Ready at T+k+2 (hit at entry k), T+ENTRIES+1 (miss), T+1 (name error).
// Backpressure: Ready low while busy; Start is ignored outside IDLE, NameByte is only accepted in COLLECT.
//
// Ports:
//   Clk, Rst             rising-edge clock, asynchronous active-high reset
//   Start/Define/ValueIn begin an operation; Define and ValueIn are latched when Start is accepted
//   NameByte/NameValid   name stream, 0x00 terminates the name
//   Ready                high in IDLE: results are valid and a new Start may be issued
//   Found/ValueOut       lookup/define hit and lookup result (ValueOut is 0 on miss)
//   Err/Full             empty or over-long name / define miss with no free slot
//   Count                number of valid entries
module var_name_table #(
    parameter int ENTRIES  = 8,
    parameter int NAME_LEN = 8,
    parameter int DATA_W   = 8
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Start,
    input  logic                           Define,
    input  logic [DATA_W-1:0]              ValueIn,
    input  logic [7:0]                     NameByte,
    input  logic                           NameValid,
    output logic                           Ready,
    output logic                           Found,
    output logic [DATA_W-1:0]              ValueOut,
    output logic                           Err,
    output logic                           Full,
    output logic [$clog2(ENTRIES+1)-1:0]   Count
);

    localparam int CW   = $clog2(ENTRIES + 1);
    localparam int EW   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int IDXW = $clog2(NAME_LEN + 1);
    localparam int BSW  = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1;

    typedef logic [NAME_LEN-1:0][7:0] name_t;
    typedef enum logic [1:0] {IDLE, COLLECT, SEARCH} state_t;

    state_t              state;
    logic                define_q;
    logic [DATA_W-1:0]   value_q;
    name_t               name_buf;
    logic [IDXW-1:0]     idx;
    logic                ovf;
    logic [EW-1:0]       ent;
    logic [ENTRIES-1:0]  valid;

    // Storage contents are gated by the valid bits and need no reset.
    name_t               names  [ENTRIES];
    logic [DATA_W-1:0]   values [ENTRIES];

    logic                hit;
    logic                last;
    logic                room;
    logic [EW-1:0]       free_idx;
    logic                wr_hit;
    logic                wr_new;

    // Unused name bytes stay 0x00, so a full-width compare distinguishes "AB" from "ABC".
    assign hit  = valid[ent] && (names[ent] == name_buf);
    assign last = (ent == EW'(ENTRIES - 1));
    assign room = (Count < CW'(ENTRIES));

    // Lowest-index invalid slot.
    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = EW'(i);
            end
        end
    end

    assign wr_hit = (state == SEARCH) && hit && define_q;
    assign wr_new = (state == SEARCH) && !hit && last && define_q && room;

    assign Ready = (state == IDLE);

    always_ff @(posedge Clk) begin
        if (wr_hit) begin
            values[ent] <= value_q;
        end
        if (wr_new) begin
            names[free_idx]  <= name_buf;
            values[free_idx] <= value_q;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            valid    <= '0;
            Count    <= '0;
            Found    <= 1'b0;
            ValueOut <= '0;
            Err      <= 1'b0;
            Full     <= 1'b0;
            define_q <= 1'b0;
            value_q  <= '0;
            name_buf <= '0;
            idx      <= '0;
            ovf      <= 1'b0;
            ent      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        define_q <= Define;
                        value_q  <= ValueIn;
                        name_buf <= '0;
                        idx      <= '0;
                        ovf      <= 1'b0;
                        Found    <= 1'b0;
                        ValueOut <= '0;
                        Err      <= 1'b0;
                        Full     <= 1'b0;
                        state    <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (NameValid) begin
                        if (NameByte != 8'h00) begin
                            if (idx < IDXW'(NAME_LEN)) begin
                                name_buf[idx[BSW-1:0]] <= NameByte;
                                idx                    <= idx + 1'b1;
                            end else begin
                                // Keep consuming until the terminator, then report the error.
                                ovf <= 1'b1;
                            end
                        end else if ((idx == '0) || ovf) begin
                            Err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            ent   <= '0;
                            state <= SEARCH;
                        end
                    end
                end

                SEARCH: begin
                    if (hit) begin
                        Found <= 1'b1;
                        if (!define_q) begin
                            ValueOut <= values[ent];
                        end
                        state <= IDLE;
                    end else if (last) begin
                        // Miss: Found/ValueOut already cleared at Start.
                        if (define_q) begin
                            if (room) begin
                                valid[free_idx] <= 1'b1;
                                Count           <= Count + 1'b1;
                            end else begin
                                Full <= 1'b1;
                            end
                        end
                        state <= IDLE;
                    end else begin
                        ent <= ent + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_var_name_table.sv
// Scoreboard bench for var_name_table: the driver pushes the hand-computed result and Ready cycle for each
// operation; a negedge monitor pops and compares whenever Ready rises. Reset-abort cases are checked inline.
module tb_var_name_table;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic        Define;
    logic [7:0]  ValueIn;
    logic [7:0]  NameByte;
    logic        NameValid;
    logic        Ready;
    logic        Found;
    logic [7:0]  ValueOut;
    logic        Err;
    logic        Full;
    logic [3:0]  Count;

    var_name_table #(.ENTRIES(8), .NAME_LEN(8), .DATA_W(8)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Define    (Define),
        .ValueIn   (ValueIn),
        .NameByte  (NameByte),
        .NameValid (NameValid),
        .Ready     (Ready),
        .Found     (Found),
        .ValueOut  (ValueOut),
        .Err       (Err),
        .Full      (Full),
        .Count     (Count)
    );

    typedef struct {
        string tag;
        int    found;
        int    val;
        int    err;
        int    full;
        int    cnt;
        int    rdy_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_rdy = 1'b1;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    // Monitor: compare on each rising edge of Ready outside reset.
    always @(negedge Clk) begin
        if (Rst) begin
            prev_rdy = Ready;
        end else begin
            if (Ready && !prev_rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready actual=1 expected=0 cyc=%0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.tag, ".found"},    int'(Found),    e.found);
                    chk({e.tag, ".value"},    int'(ValueOut), e.val);
                    chk({e.tag, ".err"},      int'(Err),      e.err);
                    chk({e.tag, ".full"},     int'(Full),     e.full);
                    chk({e.tag, ".count"},    int'(Count),    e.cnt);
                    chk({e.tag, ".ready_at"}, cyc,            e.rdy_cyc);
                end
            end
            prev_rdy = Ready;
        end
    end

    // One full operation; e_lat is Ready's cycle relative to the terminator cycle.
    task automatic op(input bit def, input logic [7:0] val, input string nm, input bit gaps, input bit sis,
                      input int e_found, input int e_val, input int e_err, input int e_full,
                      input int e_cnt, input int e_lat);
        exp_t e;
        @(negedge Clk);
        Start   = 1'b1;
        Define  = def;
        ValueIn = val;
        @(negedge Clk);
        Start   = 1'b0;
        Define  = 1'b0;
        ValueIn = 8'h00;
        for (int i = 0; i < nm.len(); i++) begin
            NameValid = 1'b1;
            NameByte  = nm[i];
            @(negedge Clk);
            if (gaps) begin
                NameValid = 1'b0;
                NameByte  = 8'h00;
                @(negedge Clk);
                @(negedge Clk);
            end
        end
        NameValid = 1'b1;
        NameByte  = 8'h00;
        e.tag     = $sformatf("%s(%s)", def ? "def" : "look", nm);
        e.found   = e_found;
        e.val     = e_val;
        e.err     = e_err;
        e.full    = e_full;
        e.cnt     = e_cnt;
        e.rdy_cyc = cyc + e_lat;
        sb.push_back(e);
        @(negedge Clk);
        NameValid = 1'b0;
        if (sis) begin
            // Start while searching must be ignored.
            Start   = 1'b1;
            Define  = 1'b1;
            ValueIn = 8'hEE;
            @(negedge Clk);
            @(negedge Clk);
            Start   = 1'b0;
            Define  = 1'b0;
            ValueIn = 8'h00;
        end
        for (int w = 0; w < 40 && sb.size() != 0; w++) @(negedge Clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout actual=not_ready expected=ready", e.tag);
            sb.delete();
        end
    endtask

    task automatic reset_pulse();
        @(negedge Clk);
        #2;
        Rst       = 1'b1;
        Start     = 1'b0;
        NameValid = 1'b0;
        NameByte  = 8'h00;
        @(negedge Clk);
        #2;
        Rst = 1'b0;
    endtask

    task automatic check_idle_clear(input string tag);
        @(negedge Clk);
        chk({tag, ".ready"}, int'(Ready),    1);
        chk({tag, ".count"}, int'(Count),    0);
        chk({tag, ".found"}, int'(Found),    0);
        chk({tag, ".value"}, int'(ValueOut), 0);
        chk({tag, ".err"},   int'(Err),      0);
        chk({tag, ".full"},  int'(Full),     0);
    endtask

    task automatic send_bytes(input string nm);
        for (int i = 0; i < nm.len(); i++) begin
            NameValid = 1'b1;
            NameByte  = nm[i];
            @(negedge Clk);
        end
        NameValid = 1'b0;
        NameByte  = 8'h00;
    endtask

    initial begin
        Rst       = 1'b1;
        Start     = 1'b0;
        Define    = 1'b0;
        ValueIn   = 8'h00;
        NameByte  = 8'h00;
        NameValid = 1'b0;
        repeat (3) @(negedge Clk);
        #2;
        Rst = 1'b0;
        check_idle_clear("reset");

        // Basic define / lookup, exact-length matching
        op(1, 8'h2A, "AB",  0, 0, 0, 8'h00, 0, 0, 1, 9);
        op(0, 8'h00, "AB",  0, 0, 1, 8'h2A, 0, 0, 1, 2);
        op(0, 8'h00, "ABC", 0, 0, 0, 8'h00, 0, 0, 1, 9);
        op(0, 8'h00, "A",   0, 0, 0, 8'h00, 0, 0, 1, 9);
        // Overwrite, gapped name stream, Start during SEARCH
        op(1, 8'h11, "AB",  0, 0, 1, 8'h00, 0, 0, 1, 2);
        op(0, 8'h00, "AB",  1, 0, 1, 8'h11, 0, 0, 1, 2);
        op(0, 8'h00, "ZZ",  0, 1, 0, 8'h00, 0, 0, 1, 9);
        op(0, 8'h00, "AB",  0, 0, 1, 8'h11, 0, 0, 1, 2);
        // Name errors
        op(0, 8'h00, "AAAAAAAAA", 0, 0, 0, 8'h00, 1, 0, 1, 1);
        op(1, 8'h77, "",          0, 0, 0, 8'h00, 1, 0, 1, 1);
        // Fill the table; 8-byte name lands in slot 1
        op(1, 8'h81, "ABCDEFGH", 0, 0, 0, 8'h00, 0, 0, 2, 9);
        for (int i = 2; i < 8; i++) begin
            op(1, 8'(8'h40 + i), $sformatf("N%0d", i), 0, 0, 0, 8'h00, 0, 0, i + 1, 9);
        end
        op(1, 8'h99, "Q",        0, 0, 0, 8'h00, 0, 1, 8, 9);
        op(1, 8'h55, "N3",       0, 0, 1, 8'h00, 0, 0, 8, 5);
        op(0, 8'h00, "N3",       0, 0, 1, 8'h55, 0, 0, 8, 5);
        op(0, 8'h00, "N7",       0, 0, 1, 8'h47, 0, 0, 8, 9);
        op(0, 8'h00, "Q",        0, 0, 0, 8'h00, 0, 0, 8, 9);
        op(0, 8'h00, "ABCDEFGH", 0, 0, 1, 8'h81, 0, 0, 8, 3);

        // Reset while collecting a name
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        send_bytes("A");
        reset_pulse();
        check_idle_clear("rst_collect");
        op(0, 8'h00, "AB", 0, 0, 0, 8'h00, 0, 0, 0, 9);
        op(1, 8'h33, "AB", 0, 0, 0, 8'h00, 0, 0, 1, 9);

        // Reset while searching
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        send_bytes("ZZ");
        NameValid = 1'b1;
        NameByte  = 8'h00;
        @(negedge Clk);
        NameValid = 1'b0;
        @(negedge Clk);
        reset_pulse();
        check_idle_clear("rst_search");
        op(0, 8'h00, "AB", 0, 0, 0, 8'h00, 0, 0, 0, 9);

        repeat (3) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
